calculadora_bcd: RTL and testbench
==================================

CALCULADORA_BCD -- requirements
Module: calculadora_bcd

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits per operand, result and display (2..16).
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd  input  4  command code: 0000-1001 digit 0-9, 1010 soma, 1011 sub, 1100 mult, 1101 reserved, 1110 igual, 1111 apagar.
REQ-005 cmd_valid  input  1  one-cycle strobe; cmd is sampled only when cmd_valid=1.
REQ-006 status  output  2  00 PRONTA, 01 OCUPADA, 10 ERRO; 11 never driven.
REQ-007 pos  output  max(1,$clog2(DIGITS))  index of the digit currently on data, 0 = least significant.
REQ-008 data  output  4  BCD digit at pos of the displayed register.
REQ-009 neg  output  1  displayed result is negative.

Function
REQ-010 State machine SHALL have states ENTRA_A, ENTRA_B, CALC, RESULT and ERRO; status SHALL be PRONTA in ENTRA_A, ENTRA_B and RESULT, OCUPADA in CALC, and ERRO in ERRO.
REQ-011 In ENTRA_A and ENTRA_B, a digit SHALL shift into the active operand at the LSD; digits beyond DIGITS already entered SHALL be ignored.
REQ-012 In ENTRA_A, an operator SHALL latch the op and go to ENTRA_B with B=0; in ENTRA_B, an operator SHALL replace the latched op when B has no digits yet.
REQ-013 In ENTRA_B with at least one digit entered, an operator SHALL first evaluate A op B, then chain the result into A with the new op latched.
REQ-014 igual SHALL go to CALC when an op is latched, and otherwise go to RESULT with result=A.
REQ-015 soma/sub SHALL spend exactly 1 cycle in CALC; sub with A<B SHALL give |A-B| with neg=1.
REQ-016 mult SHALL process B from MSD to LSD: 1 cycle for acc=acc*10, then b_i cycles for acc+=A.
REQ-017 mult CALC duration SHALL be exactly DIGITS+sum(b_i) cycles.
REQ-018 Overflow (a nonzero digit shifted out of the MSD, or a carry out of the MSD) SHALL go to ERRO.
REQ-019 In RESULT, a digit SHALL clear state and start a new A; an operator SHALL load A=result magnitude, clear neg, and go to ENTRA_B.
REQ-020 cmd 1101 in any non-CALC state SHALL go to ERRO.
REQ-021 In ERRO, every cmd except apagar SHALL be ignored, and data SHALL be 1111 at every pos.
REQ-022 apagar SHALL clear operands, op and neg and go to ENTRA_A from any state, including CALC, aborting the computation.
REQ-023 In CALC, any cmd other than apagar SHALL be dropped.
REQ-024 Display register SHALL be the active operand in ENTRA_A/ENTRA_B, the previous display in CALC, and the result in RESULT.
REQ-025 pos SHALL increment every cycle and wrap from DIGITS-1 to 0; data/pos SHALL be registered, with data corresponding to pos in the same cycle.

Reset
REQ-026 reset SHALL force ENTRA_A and clear all operands, op and accumulator.
REQ-027 In the cycle after reset: status=00, pos=0, data=0000, neg=0; reset overrides cmd_valid in the same cycle.

Configuration
REQ-028 Macro CALC_MULT_EN defined: mult SHALL be implemented as in REQ-016..REQ-018.
REQ-029 Macro CALC_MULT_EN undefined: no multiplier logic SHALL be built, and cmd 1100 SHALL behave as 1101 (go to ERRO).

Verification (DIGITS=4)
REQ-030 Stimulus 1,2,soma,3,4,igual -> 1 OCUPADA cycle, then PRONTA, display 0046, neg=0.
REQ-031 Stimulus 5,sub,9,igual -> display 0004, neg=1; then soma,1,igual -> 0005, neg=0.
REQ-032 Stimulus 9,9,mult,9,9,igual (CALC_MULT_EN defined) -> exactly 22 OCUPADA cycles, display 9801.
REQ-033 Stimulus 9,9,9,9,soma,1,igual -> status=10, data=1111 at all pos; then apagar -> status=00, display 0000.
REQ-034 Stimulus cmd 1101 -> ERRO; cmd 5 -> still ERRO; with CALC_MULT_EN undefined, cmd 1100 -> ERRO.
REQ-035 Stimulus reset asserted in the 5th OCUPADA cycle of 99*99 -> next cycle status=00, pos=0, data=0, neg=0; a following 1,igual -> display 0001.

Source files
------------

// File: rtl/calculadora_bcd_if.sv
// Command/display bus of the BCD calculator: keypad command strobe in,
// status plus time-multiplexed display digit out.
interface calculadora_bcd_if #(
    parameter int DIGITS = 4
);
    localparam int PW = ($clog2(DIGITS) < 1) ? 1 : $clog2(DIGITS);

    logic [3:0]    cmd;
    logic          cmd_valid;
    logic [1:0]    status;
    logic [PW-1:0] pos;
    logic [3:0]    data;
    logic          neg;

    modport master (
        output cmd, cmd_valid,
        input  status, pos, data, neg
    );

    modport slave (
        input  cmd, cmd_valid,
        output status, pos, data, neg
    );
endinterface

// File: rtl/calculadora_bcd.sv
// DIGITS-digit BCD calculator (soma/sub, optional mult) with a scanned display.
// Define CALC_MULT_EN to build the multiplier; otherwise cmd 1100 is an error.
module calculadora_bcd #(
    parameter int DIGITS = 4
) (
    input  logic             clock,
    input  logic             reset,
    calculadora_bcd_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = ($clog2(DIGITS) < 1) ? 1 : $clog2(DIGITS);
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {ENTRA_A, ENTRA_B, CALC, RESULT, ERRO} state_t;
    typedef enum logic [1:0] {OP_SOMA, OP_SUB, OP_MULT} op_t;

    state_t        state_reg;
    op_t           op_reg, next_op_reg, cmd_op;
    logic          chain_reg, neg_reg;
    logic [W-1:0]  a_reg, b_reg, result_reg, held_reg, disp_word;
    logic [CW-1:0] a_cnt_reg, b_cnt_reg;
    logic [PW-1:0] pos_reg, pos_next;
    logic [3:0]    data_reg;
    logic [1:0]    status;
    logic          is_digit, is_op, is_bad, is_igual, is_apagar;
    logic [W:0]    sum_w;
    logic [W-1:0]  diff, fin_val;
    logic          a_lt_b, fin_now, fin_err, fin_neg;
`ifdef CALC_MULT_EN
    logic [W-1:0]  acc_reg, acc_next, acc_sh;
    logic [W:0]    acc_add;
    logic [PW-1:0] mul_idx_reg, idx_next;
    logic [3:0]    mul_rem_reg, rem_next, b_dig;
    logic          mul_add_reg, add_next;
`endif

    function automatic logic [W:0] bcd_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] r;
        int         c, t;
        r = '0;
        c = 0;
        for (int i = 0; i < DIGITS; i++) begin
            t = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + c;
            c = (t > 9) ? 1 : 0;
            if (t > 9) t = t - 10;
            r[4*i +: 4] = 4'(t);
        end
        r[W] = (c != 0);
        return r;
    endfunction

    // x >= y is guaranteed by the caller, so no final borrow remains.
    function automatic logic [W-1:0] bcd_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        int           bw, t;
        r  = '0;
        bw = 0;
        for (int i = 0; i < DIGITS; i++) begin
            t  = int'(x[4*i +: 4]) - int'(y[4*i +: 4]) - bw;
            bw = (t < 0) ? 1 : 0;
            if (t < 0) t = t + 10;
            r[4*i +: 4] = 4'(t);
        end
        return r;
    endfunction

    always_comb begin
        is_digit  = (bus.cmd <= 4'd9);
        is_igual  = (bus.cmd == 4'hE);
        is_apagar = (bus.cmd == 4'hF);
        is_op     = 1'b0;
        is_bad    = 1'b0;
        cmd_op    = OP_SOMA;
        case (bus.cmd)
            4'hA: is_op = 1'b1;
            4'hB: begin is_op = 1'b1; cmd_op = OP_SUB; end
`ifdef CALC_MULT_EN
            4'hC: begin is_op = 1'b1; cmd_op = OP_MULT; end
`else
            4'hC: is_bad = 1'b1;
`endif
            4'hD: is_bad = 1'b1;
            default: ;
        endcase
    end

    // One CALC step: soma/sub finish at once, mult walks B from its MSD.
    always_comb begin
        sum_w   = bcd_add(a_reg, b_reg);
        a_lt_b  = (a_reg < b_reg);
        diff    = a_lt_b ? bcd_sub(b_reg, a_reg) : bcd_sub(a_reg, b_reg);
        fin_now = 1'b0;
        fin_err = 1'b0;
        fin_neg = 1'b0;
        fin_val = sum_w[W-1:0];
`ifdef CALC_MULT_EN
        acc_next = acc_reg;
        idx_next = mul_idx_reg;
        rem_next = mul_rem_reg;
        add_next = mul_add_reg;
        acc_sh   = {acc_reg[W-5:0], 4'h0};
        acc_add  = bcd_add(acc_reg, a_reg);
        b_dig    = b_reg[4*mul_idx_reg +: 4];
`endif
        case (op_reg)
            OP_SOMA: begin
                fin_err = sum_w[W];
                fin_now = !sum_w[W];
            end
            OP_SUB: begin
                fin_now = 1'b1;
                fin_val = diff;
                fin_neg = a_lt_b;
            end
`ifdef CALC_MULT_EN
            OP_MULT: begin
                if (!mul_add_reg) begin
                    acc_next = acc_sh;
                    fin_val  = acc_sh;
                    if (acc_reg[W-1 -: 4] != 4'h0) begin
                        fin_err = 1'b1;
                    end else if (b_dig == 4'h0) begin
                        if (mul_idx_reg == '0) fin_now = 1'b1;
                        else idx_next = mul_idx_reg - 1'b1;
                    end else begin
                        add_next = 1'b1;
                        rem_next = b_dig;
                    end
                end else begin
                    acc_next = acc_add[W-1:0];
                    fin_val  = acc_add[W-1:0];
                    if (acc_add[W]) begin
                        fin_err = 1'b1;
                    end else if (mul_rem_reg == 4'd1) begin
                        if (mul_idx_reg == '0) begin
                            fin_now = 1'b1;
                        end else begin
                            idx_next = mul_idx_reg - 1'b1;
                            add_next = 1'b0;
                        end
                    end else begin
                        rem_next = mul_rem_reg - 4'd1;
                    end
                end
            end
`endif
            default: fin_now = 1'b1;
        endcase
    end

    always_comb begin
        case (state_reg)
            ENTRA_A: disp_word = a_reg;
            ENTRA_B: disp_word = b_reg;
            CALC:    disp_word = held_reg;
            RESULT:  disp_word = result_reg;
            default: disp_word = {DIGITS{4'hF}};
        endcase
        case (state_reg)
            CALC:    status = 2'b01;
            ERRO:    status = 2'b10;
            default: status = 2'b00;
        endcase
        pos_next = (pos_reg == PW'(DIGITS - 1)) ? '0 : pos_reg + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ENTRA_A;
            op_reg      <= OP_SOMA;
            next_op_reg <= OP_SOMA;
            chain_reg   <= 1'b0;
            neg_reg     <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            a_cnt_reg   <= '0;
            b_cnt_reg   <= '0;
            result_reg  <= '0;
            held_reg    <= '0;
            pos_reg     <= '0;
            data_reg    <= '0;
`ifdef CALC_MULT_EN
            acc_reg     <= '0;
            mul_idx_reg <= '0;
            mul_rem_reg <= '0;
            mul_add_reg <= 1'b0;
`endif
        end else begin
            // data is fetched for the pos it will be shown with
            pos_reg  <= pos_next;
            data_reg <= disp_word[4*pos_next +: 4];
            if (state_reg != CALC) begin
                held_reg <= disp_word;
`ifdef CALC_MULT_EN
                acc_reg     <= '0;
                mul_idx_reg <= PW'(DIGITS - 1);
                mul_rem_reg <= '0;
                mul_add_reg <= 1'b0;
`endif
            end
            if (bus.cmd_valid && is_apagar) begin
                state_reg <= ENTRA_A;
                op_reg    <= OP_SOMA;
                chain_reg <= 1'b0;
                neg_reg   <= 1'b0;
                a_reg     <= '0;
                b_reg     <= '0;
                a_cnt_reg <= '0;
                b_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    ENTRA_A: if (bus.cmd_valid) begin
                        if (is_digit) begin
                            if (a_cnt_reg < CW'(DIGITS)) begin
                                a_reg     <= {a_reg[W-5:0], bus.cmd};
                                a_cnt_reg <= a_cnt_reg + 1'b1;
                            end
                        end else if (is_op) begin
                            op_reg    <= cmd_op;
                            b_reg     <= '0;
                            b_cnt_reg <= '0;
                            state_reg <= ENTRA_B;
                        end else if (is_igual) begin
                            result_reg <= a_reg;
                            neg_reg    <= 1'b0;
                            state_reg  <= RESULT;
                        end else if (is_bad) begin
                            state_reg <= ERRO;
                        end
                    end
                    ENTRA_B: if (bus.cmd_valid) begin
                        if (is_digit) begin
                            if (b_cnt_reg < CW'(DIGITS)) begin
                                b_reg     <= {b_reg[W-5:0], bus.cmd};
                                b_cnt_reg <= b_cnt_reg + 1'b1;
                            end
                        end else if (is_op) begin
                            if (b_cnt_reg == '0) begin
                                op_reg <= cmd_op;
                            end else begin
                                chain_reg   <= 1'b1;
                                next_op_reg <= cmd_op;
                                state_reg   <= CALC;
                            end
                        end else if (is_igual) begin
                            chain_reg <= 1'b0;
                            state_reg <= CALC;
                        end else if (is_bad) begin
                            state_reg <= ERRO;
                        end
                    end
                    CALC: begin
`ifdef CALC_MULT_EN
                        acc_reg     <= acc_next;
                        mul_idx_reg <= idx_next;
                        mul_rem_reg <= rem_next;
                        mul_add_reg <= add_next;
`endif
                        if (fin_err) begin
                            state_reg <= ERRO;
                        end else if (fin_now) begin
                            if (chain_reg) begin
                                a_reg     <= fin_val;
                                a_cnt_reg <= CW'(DIGITS);
                                b_reg     <= '0;
                                b_cnt_reg <= '0;
                                op_reg    <= next_op_reg;
                                chain_reg <= 1'b0;
                                state_reg <= ENTRA_B;
                            end else begin
                                result_reg <= fin_val;
                                neg_reg    <= fin_neg;
                                state_reg  <= RESULT;
                            end
                        end
                    end
                    RESULT: if (bus.cmd_valid) begin
                        if (is_digit) begin
                            a_reg     <= {{(W-4){1'b0}}, bus.cmd};
                            a_cnt_reg <= CW'(1);
                            b_reg     <= '0;
                            b_cnt_reg <= '0;
                            op_reg    <= OP_SOMA;
                            neg_reg   <= 1'b0;
                            state_reg <= ENTRA_A;
                        end else if (is_op) begin
                            a_reg     <= result_reg;
                            a_cnt_reg <= CW'(DIGITS);
                            b_reg     <= '0;
                            b_cnt_reg <= '0;
                            op_reg    <= cmd_op;
                            neg_reg   <= 1'b0;
                            state_reg <= ENTRA_B;
                        end else if (is_bad) begin
                            state_reg <= ERRO;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.status = status;
    assign bus.pos    = pos_reg;
    assign bus.data   = data_reg;
    assign bus.neg    = neg_reg;
endmodule

// File: tb/tb_calculadora_bcd.sv
// Directed-vector bench for calculadora_bcd (DIGITS=4); adapts the mult
// vectors to whether CALC_MULT_EN is defined.
module tb_calculadora_bcd;
    localparam int DIGITS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_bad    = 0;

    calculadora_bcd_if #(.DIGITS(DIGITS)) bus_if ();

    calculadora_bcd #(.DIGITS(DIGITS)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] c);
        bus_if.cmd       = c;
        bus_if.cmd_valid = 1'b1;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd       = 4'h0;
    endtask

    // codes are packed nibbles, first command in the most significant nibble
    task automatic run(input logic [31:0] codes, input int n);
        for (int i = 0; i < n; i++) send(codes[4*(n-1-i) +: 4]);
    endtask

    task automatic read_disp(output logic [15:0] d);
        repeat (2) @(negedge clk);
        d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d[4*bus_if.pos +: 4] = bus_if.data;
            @(negedge clk);
        end
    endtask

    task automatic txn(input string tag, input logic [31:0] codes, input int n,
                       input int exp_busy, input logic [1:0] exp_status,
                       input logic [15:0] exp_disp, input logic exp_neg);
        int          busy;
        logic [15:0] d;
        run(codes, n);
        busy = 0;
        for (int i = 0; i < 200 && bus_if.status == 2'b01; i++) begin
            busy++;
            @(negedge clk);
        end
        check({tag, ".busy"}, busy, exp_busy);
        check({tag, ".status"}, {30'd0, bus_if.status}, {30'd0, exp_status});
        read_disp(d);
        check({tag, ".disp"}, {16'd0, d}, {16'd0, exp_disp});
        check({tag, ".neg"}, {31'd0, bus_if.neg}, {31'd0, exp_neg});
        $display("txn %s: busy=%0d status=%0d display=%h neg=%0d", tag, busy, bus_if.status, d, bus_if.neg);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".status"}, {30'd0, bus_if.status}, 32'd0);
        check({tag, ".pos"}, {30'd0, bus_if.pos}, 32'd0);
        check({tag, ".data"}, {28'd0, bus_if.data}, 32'd0);
        check({tag, ".neg"}, {31'd0, bus_if.neg}, 32'd0);
        $display("txn %s: status=%0d pos=%0d data=%h neg=%0d", tag, bus_if.status, bus_if.pos, bus_if.data, bus_if.neg);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.cmd       = 4'h5;
        bus_if.cmd_valid = 1'b1;
        rst              = 1'b1;
        repeat (3) @(negedge clk);
        rst              = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd       = 4'h0;
        check_reset("reset");

        txn("add",       32'h12A34E,   6, 1, 2'b00, 16'h0046, 1'b0);
        txn("sub_neg",   32'h5B9E,     4, 1, 2'b00, 16'h0004, 1'b1);
        txn("sub_chain", 32'hA1E,      3, 1, 2'b00, 16'h0005, 1'b0);
        txn("ovf_add",   32'hF9999A1E, 8, 1, 2'b10, 16'hFFFF, 1'b0);
        txn("clear",     32'hF,        1, 0, 2'b00, 16'h0000, 1'b0);
        txn("limit",     32'h12345,    5, 0, 2'b00, 16'h1234, 1'b0);
        txn("eq_noop",   32'hE,        1, 0, 2'b00, 16'h1234, 1'b0);
        txn("sub_pos",   32'hF50B8E,   6, 1, 2'b00, 16'h0042, 1'b0);
        txn("sub_zero",  32'hF7B7E,    5, 1, 2'b00, 16'h0000, 1'b0);
        txn("chain1",    32'hF2A3A,    5, 1, 2'b00, 16'h0000, 1'b0);
        txn("chain2",    32'h4E,       2, 1, 2'b00, 16'h0009, 1'b0);
        txn("calc_drop", 32'hF1A2E7,   6, 0, 2'b00, 16'h0003, 1'b0);
        txn("op_repl",   32'hF8AB3E,   6, 1, 2'b00, 16'h0005, 1'b0);
        txn("resv",      32'hFD,       2, 0, 2'b10, 16'hFFFF, 1'b0);
        txn("err_hold",  32'h5E,       2, 0, 2'b10, 16'hFFFF, 1'b0);
        txn("err_clr",   32'hF,        1, 0, 2'b00, 16'h0000, 1'b0);
`ifdef CALC_MULT_EN
        txn("mul99",     32'h99C99E,   6, 22, 2'b00, 16'h9801, 1'b0);
        txn("mul12x3",   32'hF12C3E,   6, 7,  2'b00, 16'h0036, 1'b0);
        txn("mul_ovf",   32'hF5000C2E, 8, 6,  2'b10, 16'hFFFF, 1'b0);
        // reset lands on the edge that ends the 5th busy cycle
        run(32'hF99C99E, 7);
        check("rst_calc.busy", {30'd0, bus_if.status}, 32'd1);
        repeat (4) @(negedge clk);
        check("rst_calc.busy5", {30'd0, bus_if.status}, 32'd1);
`else
        txn("mul_dis",   32'hF3C,      2, 0, 2'b10, 16'hFFFF, 1'b0);
        run(32'hF1A2E, 5);
        check("rst_calc.busy", {30'd0, bus_if.status}, 32'd1);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("rst_calc");
        txn("post_rst",  32'h1E,       2, 0, 2'b00, 16'h0001, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
